// File: rtl/projection_scheduler.sv
// projection_scheduler: per-frame walker that fetches particle positions from
// BRAM and hands them one at a time to the sphere projector, with a watchdog
// that skips particles whose result never arrives.
module projection_scheduler #(
  parameter int unsigned NUM_PARTICLES  = 64,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter int unsigned BRAM_LATENCY   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  rd_en_out,
  input  logic [15:0]           rd_x_in,
  input  logic [15:0]           rd_y_in,
  input  logic [15:0]           rd_z_in,
  output logic [15:0]           proj_x_out,
  output logic [15:0]           proj_y_out,
  output logic [15:0]           proj_z_out,
  output logic                  proj_valid_out,
  input  logic                  proj_ready_in,
  input  logic                  proj_done_in,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [15:0]           results_count_out,
  output logic [15:0]           timeout_count_out,
  output logic                  overrun_out
);

  localparam int unsigned FCNT_W = $clog2(BRAM_LATENCY + 1);
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(NUM_PARTICLES - 1);
  localparam logic [FCNT_W-1:0]     FETCH_LAST = FCNT_W'(BRAM_LATENCY);
  localparam logic [TCNT_W-1:0]     TO_LAST    = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]           CNT_MAX    = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    rd_en_q, rd_en_d;
  logic [15:0]             px_q, px_d, py_q, py_d, pz_q, pz_d;
  logic                    valid_q, valid_d;
  logic                    busy_q, busy_d;
  logic                    fdone_q, fdone_d;
  logic [15:0]             results_q, results_d;
  logic [15:0]             timeouts_q, timeouts_d;
  logic                    overrun_q, overrun_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;

  logic last_c;
  logic wait_exit_c;

  assign last_c      = (addr_q == LAST_IDX);
  assign wait_exit_c = proj_done_in || (tcnt_q == TO_LAST);

  // State and output registers; reset aborts any pass without a done pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rd_en_q    <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      pz_q       <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      fdone_q    <= 1'b0;
      results_q  <= '0;
      timeouts_q <= '0;
      overrun_q  <= 1'b0;
      fcnt_q     <= '0;
      tcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_en_q    <= rd_en_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pz_q       <= pz_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      fdone_q    <= fdone_d;
      results_q  <= results_d;
      timeouts_q <= timeouts_d;
      overrun_q  <= overrun_d;
      fcnt_q     <= fcnt_d;
      tcnt_q     <= tcnt_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (frame_start_in) state_d = S_FETCH;
      S_FETCH: if (fcnt_q == FETCH_LAST) state_d = S_ISSUE;
      S_ISSUE: if (proj_ready_in) state_d = S_WAIT;
      S_WAIT:  if (wait_exit_c) state_d = last_c ? S_DONE : S_FETCH;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of outputs, counters and the particle index
  always_comb begin
    addr_d     = addr_q;
    rd_en_d    = 1'b0;
    px_d       = px_q;
    py_d       = py_q;
    pz_d       = pz_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    fdone_d    = 1'b0;
    results_d  = results_q;
    timeouts_d = timeouts_q;
    overrun_d  = overrun_q | (frame_start_in && (state_q != S_IDLE));
    fcnt_d     = fcnt_q;
    tcnt_d     = tcnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start_in) begin
          addr_d     = '0;
          rd_en_d    = 1'b1;
          busy_d     = 1'b1;
          results_d  = '0;
          timeouts_d = '0;
          overrun_d  = 1'b0;
          fcnt_d     = '0;
        end
      end
      S_FETCH: begin
        fcnt_d = fcnt_q + FCNT_W'(1);
        // BRAM data is valid exactly BRAM_LATENCY cycles after the read pulse
        if (fcnt_q == FETCH_LAST) begin
          px_d = rd_x_in;
          py_d = rd_y_in;
          pz_d = rd_z_in;
        end
      end
      S_ISSUE: begin
        if (proj_ready_in) begin
          valid_d = 1'b1;
          tcnt_d  = '0;
        end
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + TCNT_W'(1);
        // A result arriving on the watchdog's last cycle counts as a result
        if (proj_done_in) begin
          if (results_q != CNT_MAX) results_d = results_q + 16'd1;
        end else if (tcnt_q == TO_LAST) begin
          if (timeouts_q != CNT_MAX) timeouts_d = timeouts_q + 16'd1;
        end
        if (wait_exit_c) begin
          if (last_c) begin
            busy_d  = 1'b0;
            fdone_d = 1'b1;
          end else begin
            addr_d  = addr_q + ADDR_WIDTH'(1);
            rd_en_d = 1'b1;
            fcnt_d  = '0;
          end
        end
      end
      S_DONE: begin
      end
      default: begin
      end
    endcase
  end

  assign addr_out          = addr_q;
  assign rd_en_out         = rd_en_q;
  assign proj_x_out        = px_q;
  assign proj_y_out        = py_q;
  assign proj_z_out        = pz_q;
  assign proj_valid_out    = valid_q;
  assign busy_out          = busy_q;
  assign frame_done_out    = fdone_q;
  assign results_count_out = results_q;
  assign timeout_count_out = timeouts_q;
  assign overrun_out       = overrun_q;

endmodule

// File: tb/tb_projection_scheduler.sv
// Testbench for projection_scheduler: BRAM and projector models driven on the
// falling edge, expectations queued at stimulus time and checked by a monitor.
module tb_projection_scheduler;

  localparam int unsigned NP  = 4;
  localparam int unsigned AW  = 6;
  localparam int unsigned LAT = 2;
  localparam int unsigned TO  = 16;

  logic          clk;
  logic          rst_in;
  logic          frame_start_in;
  logic [AW-1:0] addr_out;
  logic          rd_en_out;
  logic [15:0]   rd_x_in, rd_y_in, rd_z_in;
  logic [15:0]   proj_x_out, proj_y_out, proj_z_out;
  logic          proj_valid_out;
  logic          proj_ready_in;
  logic          proj_done_in;
  logic          busy_out;
  logic          frame_done_out;
  logic [15:0]   results_count_out;
  logic [15:0]   timeout_count_out;
  logic          overrun_out;

  projection_scheduler #(
    .NUM_PARTICLES (NP),
    .ADDR_WIDTH    (AW),
    .BRAM_LATENCY  (LAT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst_in),
    .frame_start_in    (frame_start_in),
    .addr_out          (addr_out),
    .rd_en_out         (rd_en_out),
    .rd_x_in           (rd_x_in),
    .rd_y_in           (rd_y_in),
    .rd_z_in           (rd_z_in),
    .proj_x_out        (proj_x_out),
    .proj_y_out        (proj_y_out),
    .proj_z_out        (proj_z_out),
    .proj_valid_out    (proj_valid_out),
    .proj_ready_in     (proj_ready_in),
    .proj_done_in      (proj_done_in),
    .busy_out          (busy_out),
    .frame_done_out    (frame_done_out),
    .results_count_out (results_count_out),
    .timeout_count_out (timeout_count_out),
    .overrun_out       (overrun_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Particle table held in the BRAM model
  logic [15:0] tbl_x [4] = '{16'h3C00, 16'hC000, 16'h4248, 16'h0001};
  logic [15:0] tbl_y [4] = '{16'h4000, 16'hBC00, 16'h7BFF, 16'h8001};
  logic [15:0] tbl_z [4] = '{16'h4400, 16'h3800, 16'hC500, 16'h5640};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic miss(input string name);
    n_chk++;
    $display("FAIL %s: got unexpected event want none", name);
  endtask

  // BRAM model: data present only across the edge BRAM_LATENCY cycles after rd_en
  logic [LAT:0] pv;
  int pa [0:LAT];
  initial begin
    pv = '0;
    for (int i = 0; i <= int'(LAT); i++) pa[i] = 0;
    rd_x_in = 16'hDEAD; rd_y_in = 16'hBEEF; rd_z_in = 16'hCAFE;
  end
  always @(negedge clk) begin
    pv = {pv[LAT-1:0], rd_en_out};
    for (int i = int'(LAT); i > 0; i--) pa[i] = pa[i-1];
    pa[0] = int'(addr_out);
    if (pv[LAT] && pa[LAT] < int'(NP)) begin
      rd_x_in = tbl_x[pa[LAT]];
      rd_y_in = tbl_y[pa[LAT]];
      rd_z_in = tbl_z[pa[LAT]];
    end else begin
      rd_x_in = 16'hDEAD; rd_y_in = 16'hBEEF; rd_z_in = 16'hCAFE;
    end
  end

  // Projector model: done pulse done_delay cycles after valid, except skip_idx
  int dcnt = 0;
  int done_delay = 10;
  int skip_idx = -1;
  int n_issue = 0;
  initial proj_done_in = 1'b0;
  always @(negedge clk) begin
    proj_done_in = 1'b0;
    if (rst_in) dcnt = 0;
    else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) proj_done_in = 1'b1;
      end
      if (proj_valid_out) begin
        if (n_issue != skip_idx) dcnt = done_delay;
        n_issue++;
      end
    end
  end

  // Scoreboard queues
  int q_addr [$];
  int q_data [$];
  int q_gap  [$];
  int q_res  [$];
  int q_to   [$];

  int  cyc = 0;
  int  vcyc = 0;
  bit  gap_pend = 1'b0;
  bit  mon_en = 1'b0;
  int  fd_cnt = 0;
  int  valid_cnt = 0;

  // Monitor: pops and compares whenever the DUT presents an event
  always @(negedge clk) begin
    int e;
    cyc++;
    if (frame_done_out) fd_cnt++;
    if (proj_valid_out) valid_cnt++;
    if (mon_en) begin
      if ((rd_en_out || frame_done_out) && gap_pend) begin
        gap_pend = 1'b0;
        if (q_gap.size() == 0) miss("gap");
        else begin
          e = q_gap.pop_front();
          chk("valid_to_advance_cycles", 32'(cyc - vcyc), 32'(e));
        end
      end
      if (rd_en_out) begin
        if (q_addr.size() == 0) miss("rd_en");
        else begin
          e = q_addr.pop_front();
          chk("addr", 32'(addr_out), 32'(e));
        end
      end
      if (proj_valid_out) begin
        vcyc = cyc;
        gap_pend = 1'b1;
        if (q_data.size() == 0) miss("proj_valid");
        else begin
          e = q_data.pop_front();
          chk("proj_x", 32'(proj_x_out), 32'(tbl_x[e]));
          chk("proj_y", 32'(proj_y_out), 32'(tbl_y[e]));
          chk("proj_z", 32'(proj_z_out), 32'(tbl_z[e]));
        end
      end
      if (frame_done_out) begin
        if (q_res.size() == 0) miss("frame_done");
        else begin
          chk("results_count", 32'(results_count_out), 32'(q_res.pop_front()));
          chk("timeout_count", 32'(timeout_count_out), 32'(q_to.pop_front()));
          chk("busy_at_done", 32'(busy_out), 32'd0);
        end
      end
    end
  end

  // Queue one pass: gap = cycles from valid to next rd_en/frame_done
  task automatic push_frame(input int skip, input int gap_ok, input int gap_skip,
                            input int res, input int tos);
    for (int i = 0; i < int'(NP); i++) begin
      q_addr.push_back(i);
      q_data.push_back(i);
      q_gap.push_back((i == skip) ? gap_skip : gap_ok);
    end
    q_res.push_back(res);
    q_to.push_back(tos);
  endtask

  task automatic pulse_start();
    n_issue = 0;
    frame_start_in = 1'b1;
    @(negedge clk);
    frame_start_in = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    int guard;
    guard = 0;
    while (fd_cnt < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    chk("frame_done_seen", 32'(fd_cnt >= target), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic all_zero();
    return ~|{addr_out, rd_en_out, proj_x_out, proj_y_out, proj_z_out, proj_valid_out,
              busy_out, frame_done_out, results_count_out, timeout_count_out, overrun_out};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    int vbase;
    logic [15:0] hx, hy, hz;
    bit bad;
    rst_in = 1'b1;
    frame_start_in = 1'b0;
    proj_ready_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", 32'(all_zero()), 32'd1);
    rst_in = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic pass: done 10 cycles after each valid
    done_delay = 10; skip_idx = -1;
    base = fd_cnt; vbase = valid_cnt;
    push_frame(-1, 11, 16, 4, 0);
    pulse_start();
    wait_fd(base + 1);
    chk("one_frame_done", 32'(fd_cnt - base), 32'd1);
    chk("four_valids", 32'(valid_cnt - vbase), 32'd4);
    chk("busy_low_after", 32'(busy_out), 32'd0);

    // Ready held low in ISSUE
    proj_ready_in = 1'b0;
    base = fd_cnt;
    push_frame(-1, 11, 16, 4, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    vbase = valid_cnt;
    hx = proj_x_out; hy = proj_y_out; hz = proj_z_out;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (proj_valid_out || proj_x_out != hx || proj_y_out != hy || proj_z_out != hz) bad = 1'b1;
    end
    chk("stall_no_valid_stable", 32'(bad), 32'd0);
    chk("stall_valid_count", 32'(valid_cnt - vbase), 32'd0);
    chk("stall_hold_x", 32'(proj_x_out), 32'(tbl_x[0]));
    proj_ready_in = 1'b1;
    @(negedge clk);
    chk("valid_after_ready", 32'(proj_valid_out), 32'd1);
    wait_fd(base + 1);

    // Particle 2 never completes: 16-cycle watchdog
    done_delay = 10; skip_idx = 2;
    base = fd_cnt;
    push_frame(2, 11, 16, 3, 1);
    pulse_start();
    wait_fd(base + 1);

    // Done lands on the watchdog's last cycle: counted as result
    done_delay = 15; skip_idx = -1;
    base = fd_cnt;
    push_frame(-1, 16, 16, 4, 0);
    pulse_start();
    wait_fd(base + 1);

    // Done one cycle too late: every particle times out, late pulses ignored
    done_delay = 16;
    base = fd_cnt;
    push_frame(-1, 16, 16, 0, 4);
    pulse_start();
    wait_fd(base + 1);

    // Overrun: frame_start mid-pass ignored, sticky until next accepted start
    done_delay = 10;
    base = fd_cnt;
    push_frame(-1, 11, 16, 4, 0);
    pulse_start();
    repeat (10) @(negedge clk);
    frame_start_in = 1'b1;
    @(negedge clk);
    frame_start_in = 1'b0;
    chk("overrun_set", 32'(overrun_out), 32'd1);
    chk("overrun_busy", 32'(busy_out), 32'd1);
    wait_fd(base + 1);
    chk("overrun_sticky", 32'(overrun_out), 32'd1);
    base = fd_cnt;
    push_frame(-1, 11, 16, 4, 0);
    pulse_start();
    chk("restart_overrun_clr", 32'(overrun_out), 32'd0);
    chk("restart_results_clr", 32'(results_count_out), 32'd0);
    chk("restart_timeouts_clr", 32'(timeout_count_out), 32'd0);
    chk("restart_busy", 32'(busy_out), 32'd1);
    chk("restart_rd_en", 32'(rd_en_out), 32'd1);
    wait_fd(base + 1);

    // Reset during WAIT_RESULT of particle 1
    base = fd_cnt; vbase = valid_cnt;
    push_frame(-1, 11, 16, 4, 0);
    pulse_start();
    for (int g = 0; g < 500 && valid_cnt < vbase + 2; g++) @(negedge clk);
    chk("reached_particle1", 32'(valid_cnt - vbase), 32'd2);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    rst_in = 1'b1;
    @(negedge clk);
    chk("midpass_reset_zero", 32'(all_zero()), 32'd1);
    rst_in = 1'b0;
    q_addr.delete(); q_data.delete(); q_gap.delete(); q_res.delete(); q_to.delete();
    gap_pend = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", 32'(fd_cnt - base), 32'd0);
    chk("idle_after_reset", 32'(busy_out), 32'd0);
    mon_en = 1'b1;
    push_frame(-1, 11, 16, 4, 0);
    pulse_start();
    chk("restart_addr0", 32'(addr_out), 32'd0);
    wait_fd(base + 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
